ifu_fetch_unit: RTL and testbench

//  Instruction fetch stage: sole producer of the inst/imm/pc/exception bundle consumed by the decode stage.

---
 rtl/ifu_fetch_unit_pkg.sv | 31 +++
 rtl/ifu_imm_gen.sv | 33 +++
 rtl/ifu_fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_ifu_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit: opcodes, trap causes,
// reset/NOP words and the fetch FSM state encoding.
package ifu_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  localparam logic [3:0] MCAUSE_IADDR_MISALIGN = 4'd0;
  localparam logic [3:0] MCAUSE_IACCESS_FAULT  = 4'd1;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic pc_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_imm_gen.sv
// Combinational immediate extractor: picks the RV32 I/S/B/U/J layout from the opcode
// and returns the sign-extended immediate, or zero for formats without one.
module ifu_imm_gen
  import ifu_fetch_unit_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm
);

  logic [6:0] opcode;
  assign opcode = i_inst[6:0];

  // NOTE: every path assigns o_imm (default first), so no latch is inferred.
  always_comb begin
    o_imm = 32'd0;
    case (opcode)
      // CSR instructions carry their CSR address in the I-type field.
      OP_I, OP_L, OP_JALR, OP_CSR:
        o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      OP_S:
        o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      OP_B:
        o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        o_imm = {i_inst[31:12], 12'd0};
      OP_JAL:
        o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default:
        o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch stage: single-outstanding AXI4-Lite reads at PC, registered
// inst/imm/pc/trap bundle to decode under valid/ready, with flush redirect and kill/drain.
module ifu_fetch_unit
  import ifu_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC,
  parameter logic [31:0] NOP_INST_P = NOP_INST
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_inst,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc,
  output logic        o_exception,
  output logic [3:0]  o_mcause,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_flush,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic [31:0]  araddr_q, araddr_d;
  logic         arvalid_q, arvalid_d;
  logic         rready_q, rready_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  imm_q, imm_d;
  logic [31:0]  bpc_q, bpc_d;
  logic         exc_q, exc_d;
  logic [3:0]   mcause_q, mcause_d;
  logic         valid_q, valid_d;

  logic         rresp_err;
  logic [31:0]  fetched_word;
  logic [31:0]  fetched_imm;
  logic [31:0]  seq_pc;
  logic [31:0]  drain_pc;

  assign rresp_err    = (i_rresp != 2'b00);
  assign fetched_word = rresp_err ? NOP_INST_P : i_rdata;
  assign seq_pc       = pc_q + 32'd4;
  // A flush landing on the same cycle as the drained beat redirects immediately.
  assign drain_pc     = i_flush ? i_redirect_pc : pc_q;

  ifu_imm_gen u_imm_gen (
    .i_inst (fetched_word),
    .o_imm  (fetched_imm)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    inst_d    = inst_q;
    imm_d     = imm_q;
    bpc_d     = bpc_q;
    exc_d     = exc_q;
    mcause_d  = mcause_q;
    valid_d   = valid_q;

    case (state_q)
      ST_REQ: begin
        if (arvalid_q) begin
          // An offered AR must stay stable until accepted, even across a flush.
          if (i_arready) begin
            state_d   = ST_WAIT;
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
          end
          if (i_flush) begin
            kill_d = 1'b1;
            pc_d   = i_redirect_pc;
          end
        end else if (i_flush) begin
          pc_d      = i_redirect_pc;
          araddr_d  = i_redirect_pc;
          arvalid_d = pc_aligned(i_redirect_pc);
        end else if (!pc_aligned(pc_q)) begin
          state_d  = ST_HOLD;
          inst_d   = NOP_INST_P;
          imm_d    = 32'd0;
          bpc_d    = pc_q;
          exc_d    = 1'b1;
          mcause_d = MCAUSE_IADDR_MISALIGN;
          valid_d  = 1'b1;
        end else begin
          araddr_d  = pc_q;
          arvalid_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (i_rvalid) begin
          rready_d = 1'b0;
          if (kill_q || i_flush) begin
            state_d   = ST_REQ;
            kill_d    = 1'b0;
            pc_d      = drain_pc;
            araddr_d  = drain_pc;
            arvalid_d = pc_aligned(drain_pc);
          end else begin
            state_d  = ST_HOLD;
            inst_d   = fetched_word;
            imm_d    = fetched_imm;
            bpc_d    = pc_q;
            exc_d    = rresp_err;
            mcause_d = rresp_err ? MCAUSE_IACCESS_FAULT : MCAUSE_IADDR_MISALIGN;
            valid_d  = 1'b1;
          end
        end else if (i_flush) begin
          kill_d = 1'b1;
          pc_d   = i_redirect_pc;
        end
      end

      ST_HOLD: begin
        if (i_flush) begin
          state_d   = ST_REQ;
          valid_d   = 1'b0;
          pc_d      = i_redirect_pc;
          araddr_d  = i_redirect_pc;
          arvalid_d = pc_aligned(i_redirect_pc);
        end else if (i_ready && !i_stall) begin
          state_d   = ST_REQ;
          valid_d   = 1'b0;
          pc_d      = seq_pc;
          araddr_d  = seq_pc;
          arvalid_d = pc_aligned(seq_pc);
        end
      end

      default: begin
        state_d   = ST_REQ;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // NOTE: reset is synchronous and every state flop uses non-blocking assignment.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC_P;
      kill_q    <= 1'b0;
      araddr_q  <= RESET_PC_P;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      inst_q    <= NOP_INST_P;
      imm_q     <= 32'd0;
      bpc_q     <= RESET_PC_P;
      exc_q     <= 1'b0;
      mcause_q  <= 4'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      inst_q    <= inst_d;
      imm_q     <= imm_d;
      bpc_q     <= bpc_d;
      exc_q     <= exc_d;
      mcause_q  <= mcause_d;
      valid_q   <= valid_d;
    end
  end

  assign o_araddr    = araddr_q;
  assign o_arvalid   = arvalid_q;
  assign o_rready    = rready_q;
  assign o_inst      = inst_q;
  assign o_imm       = imm_q;
  assign o_pc        = bpc_q;
  assign o_exception = exc_q;
  assign o_mcause    = mcause_q;
  assign o_valid     = valid_q;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed bench for ifu_fetch_unit: the bench plays the AXI slave and decode stage
// cycle by cycle and compares outputs against hand-computed values.
module tb_ifu_fetch_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        o_rready;
  logic [31:0] o_inst;
  logic [31:0] o_imm;
  logic [31:0] o_pc;
  logic        o_exception;
  logic [3:0]  o_mcause;
  logic        o_valid;
  logic        i_ready;
  logic        i_flush;
  logic [31:0] i_redirect_pc;
  logic        i_stall;

  int n_pass = 0;
  int n_total = 0;

  always #5 i_clock = ~i_clock;

  ifu_fetch_unit dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .o_araddr      (o_araddr),
    .o_arvalid     (o_arvalid),
    .i_arready     (i_arready),
    .i_rdata       (i_rdata),
    .i_rresp       (i_rresp),
    .i_rvalid      (i_rvalid),
    .o_rready      (o_rready),
    .o_inst        (o_inst),
    .o_imm         (o_imm),
    .o_pc          (o_pc),
    .o_exception   (o_exception),
    .o_mcause      (o_mcause),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .i_flush       (i_flush),
    .i_redirect_pc (i_redirect_pc),
    .i_stall       (i_stall)
  );

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    i_reset = 1'b1;
    i_arready = 1'b0;
    i_rdata = 32'd0;
    i_rresp = 2'b00;
    i_rvalid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    i_redirect_pc = 32'd0;
    i_stall = 1'b0;
    tick();
    tick();
    check("rst_valid",   {31'd0, o_valid},     32'd0);
    check("rst_arvalid", {31'd0, o_arvalid},   32'd0);
    check("rst_rready",  {31'd0, o_rready},    32'd0);
    check("rst_exc",     {31'd0, o_exception}, 32'd0);
    check("rst_inst",    o_inst,               32'h0000_0013);
    check("rst_imm",     o_imm,                32'd0);
    check("rst_mcause",  {28'd0, o_mcause},    32'd0);
    check("rst_pc",      o_pc,                 32'h3000_0000);

    // Basic fetch: AR at reset PC, R next cycle, bundle, transfer.
    i_reset = 1'b0;
    i_arready = 1'b1;
    tick();
    check("t1_arvalid", {31'd0, o_arvalid}, 32'd1);
    check("t1_araddr",  o_araddr,           32'h3000_0000);
    tick();
    i_arready = 1'b0;
    check("t1_rready",  {31'd0, o_rready},  32'd1);
    check("t1_arv_off", {31'd0, o_arvalid}, 32'd0);
    i_rvalid = 1'b1;
    i_rdata = 32'h0050_0093;
    tick();
    i_rvalid = 1'b0;
    check("t1_valid", {31'd0, o_valid}, 32'd1);
    check("t1_inst",  o_inst,           32'h0050_0093);
    check("t1_imm",   o_imm,            32'd5);
    check("t1_pc",    o_pc,             32'h3000_0000);
    check("t1_exc",   {31'd0, o_exception}, 32'd0);
    check("t1_rr_off", {31'd0, o_rready}, 32'd0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("t1_valid_drop", {31'd0, o_valid},   32'd0);
    check("t1_next_arv",   {31'd0, o_arvalid}, 32'd1);
    check("t1_next_addr",  o_araddr,           32'h3000_0004);

    // Hold with decode not ready, then ready-but-stalled.
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_rvalid = 1'b1;
    i_rdata = 32'hfff0_0113;
    tick();
    i_rvalid = 1'b0;
    check("t2_imm", o_imm, 32'hffff_ffff);
    check("t2_pc",  o_pc,  32'h3000_0004);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", {31'd0, o_valid},   32'd1);
      check("t2_hold_inst",  o_inst,             32'hfff0_0113);
      check("t2_hold_noar",  {31'd0, o_arvalid}, 32'd0);
    end
    i_ready = 1'b1;
    i_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t2_stall_valid", {31'd0, o_valid},   32'd1);
      check("t2_stall_pc",    o_pc,               32'h3000_0004);
      check("t2_stall_noar",  {31'd0, o_arvalid}, 32'd0);
    end
    i_stall = 1'b0;
    tick();
    i_ready = 1'b0;
    check("t2_release_valid", {31'd0, o_valid}, 32'd0);
    check("t2_release_addr",  o_araddr,         32'h3000_0008);
    check("t2_release_arv",   {31'd0, o_arvalid}, 32'd1);

    // Flush during WAIT: the returning beat is drained, never presented.
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_flush = 1'b1;
    i_redirect_pc = 32'h3000_0100;
    tick();
    i_flush = 1'b0;
    check("t3_rready_kill", {31'd0, o_rready}, 32'd1);
    check("t3_valid_kill",  {31'd0, o_valid},  32'd0);
    i_rvalid = 1'b1;
    i_rdata = 32'hdead_beef;
    tick();
    i_rvalid = 1'b0;
    check("t3_drain_valid", {31'd0, o_valid},   32'd0);
    check("t3_drain_rr",    {31'd0, o_rready},  32'd0);
    check("t3_redir_arv",   {31'd0, o_arvalid}, 32'd1);
    check("t3_redir_addr",  o_araddr,           32'h3000_0100);
    tick();
    check("t3_still_invalid", {31'd0, o_valid}, 32'd0);
    check("t3_no_beef",       {31'd0, (o_inst == 32'hdead_beef)}, 32'd0);

    // Flush during REQ with AR not accepted: address holds, beat drained, refetch.
    i_flush = 1'b1;
    i_redirect_pc = 32'h3000_0200;
    tick();
    i_flush = 1'b0;
    check("t4_hold_addr0", o_araddr,           32'h3000_0100);
    check("t4_hold_arv0",  {31'd0, o_arvalid}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_hold_addr", o_araddr,           32'h3000_0100);
      check("t4_hold_arv",  {31'd0, o_arvalid}, 32'd1);
    end
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    check("t4_rready", {31'd0, o_rready}, 32'd1);
    i_rvalid = 1'b1;
    i_rdata = 32'h0010_0093;
    tick();
    i_rvalid = 1'b0;
    check("t4_drain_valid", {31'd0, o_valid},   32'd0);
    check("t4_redir_addr",  o_araddr,           32'h3000_0200);
    check("t4_redir_arv",   {31'd0, o_arvalid}, 32'd1);

    // Error response: access fault with NOP payload.
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_rvalid = 1'b1;
    i_rresp = 2'b10;
    i_rdata = 32'h1234_5678;
    tick();
    i_rvalid = 1'b0;
    i_rresp = 2'b00;
    check("t5_valid",  {31'd0, o_valid},     32'd1);
    check("t5_exc",    {31'd0, o_exception}, 32'd1);
    check("t5_mcause", {28'd0, o_mcause},    32'd1);
    check("t5_inst",   o_inst,               32'h0000_0013);
    check("t5_pc",     o_pc,                 32'h3000_0200);

    // Flush to a misaligned PC from HOLD (with i_ready): no AR, misalign trap.
    i_flush = 1'b1;
    i_ready = 1'b1;
    i_redirect_pc = 32'h3000_0102;
    tick();
    i_flush = 1'b0;
    i_ready = 1'b0;
    check("t6_valid_drop", {31'd0, o_valid},   32'd0);
    check("t6_noar0",      {31'd0, o_arvalid}, 32'd0);
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    check("t6_valid",  {31'd0, o_valid},     32'd1);
    check("t6_noar",   {31'd0, o_arvalid},   32'd0);
    check("t6_exc",    {31'd0, o_exception}, 32'd1);
    check("t6_mcause", {28'd0, o_mcause},    32'd0);
    check("t6_pc",     o_pc,                 32'h3000_0102);
    check("t6_inst",   o_inst,               32'h0000_0013);

    // Flush wins over a simultaneous transfer: fetch at redirect, not pc+4.
    i_flush = 1'b1;
    i_ready = 1'b1;
    i_redirect_pc = 32'h3000_0300;
    tick();
    i_flush = 1'b0;
    i_ready = 1'b0;
    check("t7_arv",   {31'd0, o_arvalid}, 32'd1);
    check("t7_addr",  o_araddr,           32'h3000_0300);
    check("t7_valid", {31'd0, o_valid},   32'd0);
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_rvalid = 1'b1;
    i_rdata = 32'h1234_50b7;
    tick();
    i_rvalid = 1'b0;
    check("t7_lui_imm", o_imm,                32'h1234_5000);
    check("t7_lui_pc",  o_pc,                 32'h3000_0300);
    check("t7_lui_exc", {31'd0, o_exception}, 32'd0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("t7_seq_addr", o_araddr, 32'h3000_0304);
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    i_rvalid = 1'b1;
    i_rdata = 32'hfe00_0ee3;
    tick();
    i_rvalid = 1'b0;
    check("t7_br_imm",  o_imm,  32'hffff_fffc);
    check("t7_br_pc",   o_pc,   32'h3000_0304);
    check("t7_br_inst", o_inst, 32'hfe00_0ee3);

    // Synchronous reset while a bundle is held.
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("t8_valid", {31'd0, o_valid}, 32'd0);
    check("t8_pc",    o_pc,             32'h3000_0000);
    check("t8_inst",  o_inst,           32'h0000_0013);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
